// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: 8x8 unsigned multiplier built from one shared 4x4 nibble multiplier over four steps.
// Optional macro MUL8_ZERO_SKIP_EN: zero operands go straight to DONE. Rev 1.0
`default_nettype none

module mul4x4_u (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);
  assign p = {4'b0000, x} * {4'b0000, y};
endmodule

module mul8_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] product,
  output logic        busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  step;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [15:0] acc;
  logic [3:0]  nib_x;
  logic [3:0]  nib_y;
  logic [7:0]  nib_p;
  logic [15:0] term;
  logic        accept;
  logic        zero_op;

  assign accept = start_valid & start_ready;

`ifdef MUL8_ZERO_SKIP_EN
  assign zero_op = (a == 8'h00) || (b == 8'h00);
`else
  assign zero_op = 1'b0;
`endif

  // step[1] picks the a nibble, step[0] the b nibble
  always_comb begin
    nib_x = step[1] ? op_a[7:4] : op_a[3:0];
    nib_y = step[0] ? op_b[7:4] : op_b[3:0];
  end

  mul4x4_u u_nib_mul (
    .x (nib_x),
    .y (nib_y),
    .p (nib_p)
  );

  always_comb begin
    term = 16'h0000;
    case (step)
      2'd0:    term = {8'h00, nib_p};
      2'd1:    term = {4'h0, nib_p, 4'h0};
      2'd2:    term = {4'h0, nib_p, 4'h0};
      default: term = {nib_p, 8'h00};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      step  <= 2'd0;
      op_a  <= 8'h00;
      op_b  <= 8'h00;
      acc   <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_a  <= a;
            op_b  <= b;
            acc   <= 16'h0000;
            step  <= 2'd0;
            state <= zero_op ? S_DONE : S_MUL;
          end
        end
        S_MUL: begin
          acc  <= acc + term;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign start_ready = (state == S_IDLE);
  assign res_valid   = (state == S_DONE);
  assign busy        = (state != S_IDLE);
  assign product     = acc;

endmodule

`default_nettype wire
